// File: rtl/mcr_rom_arbiter.sv
// Shares the MCR1 program/sound ROM RAM port between the HPS download writer,
// the main CPU and the sound CPU. Also owns rom_loaded and the stretched core reset.
module mcr_rom_arbiter #(
  parameter int              AW       = 16,
  parameter logic [AW-1:0]   SND_BASE = 16'h8000,
  parameter logic [15:0]     RST_HOLD = 16'hFFFF
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          user_reset,
  input  logic          dl_active,
  input  logic          dl_wr,
  input  logic [24:0]   dl_addr,
  input  logic [7:0]    dl_data,
  output logic          dl_wait,
  input  logic          cpu_req,
  input  logic [14:0]   cpu_addr,
  output logic          cpu_ack,
  output logic [7:0]    cpu_data,
  input  logic          snd_req,
  input  logic [13:0]   snd_addr,
  output logic          snd_ack,
  output logic [7:0]    snd_data,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [7:0]    mem_d,
  input  logic [7:0]    mem_q,
  output logic          rom_loaded,
  output logic          core_reset
);

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RA, S_RD} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_pend;
  logic [15:0] r_waddr;
  logic [7:0]  r_wdata;
  logic        r_rr_snd;
  logic        r_gnt_snd;
  logic        r_dl_prev;
  logic        r_loaded;
  logic [15:0] r_hold;

  logic w_cpu_elig;
  logic w_snd_elig;
  logic w_start_wr;
  logic w_start_rd;
  logic w_pick_snd;
  logic w_dl_hit;
  logic w_accept;
  logic w_cause;

  always_comb begin
    w_state_nxt = r_state;
    w_start_wr  = 1'b0;
    w_start_rd  = 1'b0;
    w_pick_snd  = 1'b0;
    // A requester is still acking its previous read this cycle, so it sits out
    w_cpu_elig  = cpu_req & ~cpu_ack;
    w_snd_elig  = snd_req & ~snd_ack;
    case (r_state)
      S_IDLE: begin
        if (r_pend) begin
          w_state_nxt = S_WR;
          w_start_wr  = 1'b1;
        end else if (!dl_active && (w_cpu_elig || w_snd_elig)) begin
          w_state_nxt = S_RA;
          w_start_rd  = 1'b1;
          w_pick_snd  = w_snd_elig & (~w_cpu_elig | ~r_rr_snd);
        end
      end
      S_WR:    w_state_nxt = S_IDLE;
      S_RA:    w_state_nxt = S_RD;
      S_RD:    w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A write landing in the WR cycle is accepted because the clear happens first
  assign w_dl_hit = dl_wr & dl_active & (dl_addr[24:16] == 9'd0);
  assign w_accept = w_dl_hit & (~r_pend | (r_state == S_WR));
  assign w_cause  = user_reset | dl_active | ~r_loaded;

  assign dl_wait    = r_pend;
  assign rom_loaded = r_loaded;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_pend     <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_rr_snd   <= 1'b1;
      r_gnt_snd  <= 1'b0;
      r_dl_prev  <= 1'b0;
      r_loaded   <= 1'b0;
      r_hold     <= RST_HOLD;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_d      <= '0;
      cpu_ack    <= 1'b0;
      snd_ack    <= 1'b0;
      cpu_data   <= '0;
      snd_data   <= '0;
      core_reset <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      mem_we  <= w_start_wr;
      cpu_ack <= 1'b0;
      snd_ack <= 1'b0;

      if (w_start_wr) begin
        mem_addr <= AW'(r_waddr);
        mem_d    <= r_wdata;
      end
      if (w_start_rd) begin
        r_gnt_snd <= w_pick_snd;
        r_rr_snd  <= w_pick_snd;
        mem_addr  <= w_pick_snd ? (SND_BASE | AW'(snd_addr)) : AW'({1'b0, cpu_addr});
      end
      if (r_state == S_RD) begin
        if (r_gnt_snd) begin
          snd_data <= mem_q;
          snd_ack  <= 1'b1;
        end else begin
          cpu_data <= mem_q;
          cpu_ack  <= 1'b1;
        end
      end

      if (r_state == S_WR) r_pend <= 1'b0;
      if (w_accept) begin
        r_pend  <= 1'b1;
        r_waddr <= dl_addr[15:0];
        r_wdata <= dl_data;
      end

      r_dl_prev <= dl_active;
      if (r_dl_prev && !dl_active) r_loaded <= 1'b1;

      // Core reset is stretched by RST_HOLD cycles after the last cause drops
      if (w_cause) r_hold <= RST_HOLD;
      else if (r_hold != 16'd0) r_hold <= r_hold - 16'd1;
      core_reset <= w_cause | (r_hold != 16'd0);
    end
  end

endmodule
